// File: rtl/cfg_stream_pkg.sv
// Shared constants and helpers for the serial configuration stream deserialiser.
// CRC16_POLY / CRC16_INIT are used only when the design is built with CFG_STREAM_CRC_EN.
package cfg_stream_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // Ceiling log2, used for pointer and bit-counter widths at elaboration time
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // One CRC-16/CCITT step, MSB-first (non-reflected), one data bit at a time
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      if (fb) begin
         return {crc[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
         return {crc[14:0], 1'b0};
      end
   endfunction

endpackage

// File: rtl/cfg_stream_fifo.sv
// Synchronous show-ahead FIFO for assembled configuration words.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write into a full FIFO succeeds only when a read happens in the same cycle.
module cfg_stream_fifo
   import cfg_stream_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_data,
   output logic              empty,
   output logic              full
);

   localparam int AW    = clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [WORD_W-1:0] mem_r [DEPTH];
   logic              empty_s;
   logic              full_s;
   logic              pop_s;
   logic              push_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s   = rd_en & ~empty_s;
   assign push_s  = wr_en & (~full_s | pop_s);

   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
   assign empty   = empty_s;
   assign full    = full_s;

   // Pointer and storage update; head slot may be rewritten as it is being consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
            wr_ptr_r                <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
      end
   end

endmodule

// File: rtl/cfg_stream_deser.sv
// Deserialiser / monitor for the SD loader serial configuration stream.
// Synchronises cfg_clk/cfg_dat into clk_i, packs bits into words, buffers them in
// a show-ahead FIFO, counts words, flags a programmable target and FIFO overflow.
// Optional feature: define CFG_STREAM_CRC_EN to enable the running CRC-16 on crc_o;
// otherwise crc_o is tied low.
module cfg_stream_deser
   import cfg_stream_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              cfg_clk_i,
   input  logic              cfg_dat_i,
   input  logic              enable_i,
   input  logic [CNT_W-1:0]  target_words_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic [CNT_W-1:0]  word_cnt_o,
   output logic              dat_done_o,
   output logic              overflow_o,
   output logic [15:0]       crc_o
);

   localparam int              BIT_W    = clog2(WORD_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

   logic              rst_meta_r;
   logic              rst_sync_r;
   logic              rst_n_s;
   logic              cclk_meta_r;
   logic              cclk_sync_r;
   logic              cclk_prev_r;
   logic              cdat_meta_r;
   logic              cdat_sync_r;
   logic              accept_s;
   logic              word_done_s;
   logic [WORD_W-1:0] shift_r;
   logic [WORD_W-1:0] shift_next_s;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic              push_pend_r;
   logic [WORD_W-1:0] push_word_r;
   logic [WORD_W-1:0] fifo_head_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;
   logic              pop_s;
   logic              drop_s;
   logic [CNT_W-1:0]  word_cnt_r;
   logic              done_r;
   logic              ovf_r;

   // Assert reset immediately, release it only on a clk_i edge
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rst_meta_r <= 1'b0;
         rst_sync_r <= 1'b0;
      end else begin
         rst_meta_r <= 1'b1;
         rst_sync_r <= rst_meta_r;
      end
   end

   assign rst_n_s = rst_sync_r;

   // Two-flop synchronisers for the serial pins plus a third clock stage for edge detect
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         cclk_meta_r <= 1'b0;
         cclk_sync_r <= 1'b0;
         cclk_prev_r <= 1'b0;
         cdat_meta_r <= 1'b0;
         cdat_sync_r <= 1'b0;
      end else begin
         cclk_meta_r <= cfg_clk_i;
         cclk_sync_r <= cclk_meta_r;
         cclk_prev_r <= cclk_sync_r;
         cdat_meta_r <= cfg_dat_i;
         cdat_sync_r <= cdat_meta_r;
      end
   end

   assign accept_s    = cclk_sync_r & ~cclk_prev_r & enable_i;
   assign word_done_s = accept_s && (bit_cnt_r == LAST_BIT);

   // Shift register contents after taking in the current synced data bit
   always_comb begin
      shift_next_s = shift_r;
      if (MSB_FIRST) begin
         shift_next_s = {shift_r[WORD_W-2:0], cdat_sync_r};
      end else begin
         shift_next_s = {cdat_sync_r, shift_r[WORD_W-1:1]};
      end
   end

   // Bit assembly; partial word and bit count simply hold while no bit is accepted
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         shift_r   <= '0;
         bit_cnt_r <= '0;
      end else if (accept_s) begin
         shift_r <= shift_next_s;
         if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_r <= '0;
         end else begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
         end
      end else begin
         shift_r   <= shift_r;
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // Completed word is staged for one cycle before being pushed
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         push_pend_r <= 1'b0;
         push_word_r <= '0;
      end else begin
         push_pend_r <= word_done_s;
         if (word_done_s) begin
            push_word_r <= shift_next_s;
         end else begin
            push_word_r <= push_word_r;
         end
      end
   end

   assign pop_s  = word_ready_i & ~fifo_empty_s;
   assign drop_s = push_pend_r & fifo_full_s & ~pop_s;

   cfg_stream_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_n_s),
      .wr_en   (push_pend_r),
      .wr_data (push_word_r),
      .rd_en   (word_ready_i),
      .rd_data (fifo_head_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s)
   );

   // Word counter (saturating) and the sticky done / overflow flags
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         word_cnt_r <= '0;
         done_r     <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         if (push_pend_r && (word_cnt_r != '1)) begin
            word_cnt_r <= word_cnt_r + CNT_W'(1'b1);
         end else begin
            word_cnt_r <= word_cnt_r;
         end
         done_r <= done_r | ((target_words_i != '0) && (word_cnt_r == target_words_i));
         ovf_r  <= ovf_r | drop_s;
      end
   end

   assign word_o       = fifo_head_s;
   assign word_valid_o = ~fifo_empty_s;
   assign word_cnt_o   = word_cnt_r;
   assign dat_done_o   = done_r;
   assign overflow_o   = ovf_r;

`ifdef CFG_STREAM_CRC_EN
   logic [15:0] crc_r;

   // Running CRC over every accepted bit in arrival order, independent of FIFO state
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         crc_r <= CRC16_INIT;
      end else if (accept_s) begin
         crc_r <= crc16_step(crc_r, cdat_sync_r);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc_o = crc_r;
`else
   assign crc_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cfg_stream_deser.sv
// Self-checking bench for cfg_stream_deser (default parameters: 8-bit words, 4-deep FIFO).
module tb_cfg_stream_deser;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset_n;
   logic        cfg_clk;
   logic        cfg_dat;
   logic        enable;
   logic [31:0] target_words;
   logic [7:0]  word;
   logic        word_valid;
   logic        word_ready;
   logic [31:0] word_cnt;
   logic        dat_done;
   logic        overflow;
   logic [15:0] crc;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int         due;
      logic [7:0] w;
   } ev_t;

   ev_t         ev_q[$];
   logic [7:0]  m_q[$];
   logic [31:0] m_cnt;
   logic        m_done;
   logic        m_ovf;

   cfg_stream_deser dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .cfg_clk_i      (cfg_clk),
      .cfg_dat_i      (cfg_dat),
      .enable_i       (enable),
      .target_words_i (target_words),
      .word_o         (word),
      .word_valid_o   (word_valid),
      .word_ready_i   (word_ready),
      .word_cnt_o     (word_cnt),
      .dat_done_o     (dat_done),
      .overflow_o     (overflow),
      .crc_o          (crc)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: words appear 4 clocks after their last rising cfg_clk edge
   initial begin
      ev_t e;
      m_cnt  = 32'd0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!reset_n) begin
            m_q.delete();
            ev_q.delete();
            m_cnt  = 32'd0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
         end else begin
            if (word_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (target_words != 32'd0 && m_cnt == target_words) m_done = 1'b1;
            while (ev_q.size() > 0 && ev_q[0].due == cyc) begin
               e = ev_q.pop_front();
               if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
               if (m_q.size() < DEPTH) m_q.push_back(e.w);
               else m_ovf = 1'b1;
            end
         end
         chk("valid", {31'd0, word_valid}, {31'd0, (m_q.size() > 0)});
         if (m_q.size() > 0) chk("word", {24'd0, word}, {24'd0, m_q[0]});
         else chk("word_idle", {24'd0, word}, word_cnt == 32'd0 ? 32'd0 : {24'd0, word});
         chk("word_cnt", word_cnt, m_cnt);
         chk("dat_done", {31'd0, dat_done}, {31'd0, m_done});
         chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      end
   end

   // One serial bit: data set while cfg_clk low, then a 3-clock high pulse
   // mode 1: check valid exactly 4 clocks after the edge; mode 2: pulse ready at the push cycle
   task automatic send_bit(input logic b, input logic last, input logic [7:0] w, input int mode);
      cfg_dat = b;
      repeat (2) @(negedge clk);
      cfg_clk = 1'b1;
      if (last) ev_q.push_back('{due: cyc + 4, w: w});
      repeat (3) @(negedge clk);
      if (mode == 1) chk("lat_not_yet", {31'd0, word_valid}, 32'd0);
      if (mode == 2) word_ready = 1'b1;
      cfg_clk = 1'b0;
      @(negedge clk);
      if (mode == 1) begin
         chk("lat_valid", {31'd0, word_valid}, 32'd1);
         chk("lat_word", {24'd0, word}, {24'd0, w});
      end
      if (mode == 2) word_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] w, input int mode);
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i], (i == 0), w, (i == 0) ? mode : 0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n      = 1'b0;
      cfg_clk      = 1'b0;
      cfg_dat      = 1'b0;
      word_ready   = 1'b0;
      target_words = 32'd0;
      enable       = 1'b1;
      @(negedge clk);
      chk("rst_valid", {31'd0, word_valid}, 32'd0);
      chk("rst_word", {24'd0, word}, 32'd0);
      chk("rst_cnt", word_cnt, 32'd0);
      chk("rst_flags", {30'd0, dat_done, overflow}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_expect(input logic [7:0] exp);
      chk("pop_valid", {31'd0, word_valid}, 32'd1);
      chk("pop_word", {24'd0, word}, {24'd0, exp});
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      string      s;
      logic [7:0] c;
      logic [15:0] crc_exp;
      reset_n      = 1'b0;
      cfg_clk      = 1'b0;
      cfg_dat      = 1'b0;
      enable       = 1'b1;
      target_words = 32'd0;
      word_ready   = 1'b0;

      // T1: single byte, latency and count
      do_reset();
      word_ready = 1'b1;
      send_byte(8'hA5, 1);
      repeat (3) @(negedge clk);
      chk("t1_cnt", word_cnt, 32'd1);

      // T2: done at target, sticky after target lowered
      do_reset();
      word_ready   = 1'b1;
      target_words = 32'd3;
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      chk("t2_not_done", {31'd0, dat_done}, 32'd0);
      send_byte(8'h03, 0);
      repeat (4) @(negedge clk);
      chk("t2_cnt", word_cnt, 32'd3);
      chk("t2_done", {31'd0, dat_done}, 32'd1);
      target_words = 32'd0;
      repeat (3) @(negedge clk);
      chk("t2_done_sticky", {31'd0, dat_done}, 32'd1);

      // T3: overflow with ready held low
      do_reset();
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
      send_byte(8'h55, 0);
      repeat (3) @(negedge clk);
      chk("t3_ovf", {31'd0, overflow}, 32'd1);
      chk("t3_cnt", word_cnt, 32'd5);
      pop_expect(8'h11);
      pop_expect(8'h22);
      pop_expect(8'h33);
      pop_expect(8'h44);
      chk("t3_empty", {31'd0, word_valid}, 32'd0);

      // T4: push into a full FIFO in the same cycle as a pop
      do_reset();
      send_byte(8'h81, 0);
      send_byte(8'h82, 0);
      send_byte(8'h83, 0);
      send_byte(8'h84, 0);
      send_byte(8'h85, 2);
      repeat (2) @(negedge clk);
      chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
      chk("t4_cnt", word_cnt, 32'd5);
      pop_expect(8'h82);
      pop_expect(8'h83);
      pop_expect(8'h84);
      pop_expect(8'h85);

      // T5: reset in the middle of a word leaves no residue
      do_reset();
      send_bit(1'b1, 1'b0, 8'h00, 0);
      send_bit(1'b0, 1'b0, 8'h00, 0);
      send_bit(1'b1, 1'b0, 8'h00, 0);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(8'h3C, 0);
      repeat (2) @(negedge clk);
      chk("t5_word", {24'd0, word}, 32'h3C);
      chk("t5_flags", {30'd0, dat_done, overflow}, 32'd0);
      chk("t5_cnt", word_cnt, 32'd1);

      // Enable low mid-word: ignored edges, partial word held
      do_reset();
      send_bit(1'b1, 1'b0, 8'h00, 0);
      send_bit(1'b1, 1'b0, 8'h00, 0);
      send_bit(1'b0, 1'b0, 8'h00, 0);
      send_bit(1'b0, 1'b0, 8'h00, 0);
      enable = 1'b0;
      send_bit(1'b1, 1'b0, 8'h00, 0);
      send_bit(1'b1, 1'b0, 8'h00, 0);
      send_bit(1'b0, 1'b0, 8'h00, 0);
      enable = 1'b1;
      send_bit(1'b0, 1'b0, 8'h00, 0);
      send_bit(1'b0, 1'b0, 8'h00, 0);
      send_bit(1'b1, 1'b0, 8'h00, 0);
      send_bit(1'b1, 1'b1, 8'hC3, 0);
      repeat (2) @(negedge clk);
      chk("en_word", {24'd0, word}, 32'hC3);
      chk("en_cnt", word_cnt, 32'd1);

      // T6: CRC over "123456789"
      do_reset();
      word_ready = 1'b1;
      s = "123456789";
      for (int i = 0; i < 9; i++) begin
         c = s[i];
         send_byte(c, 0);
      end
      repeat (4) @(negedge clk);
      chk("t6_cnt", word_cnt, 32'd9);
`ifdef CFG_STREAM_CRC_EN
      crc_exp = 16'h29B1;
`else
      crc_exp = 16'h0000;
`endif
      chk("t6_crc", {16'd0, crc}, {16'd0, crc_exp});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
